// File: rtl/sdp_ram_rf_1024x32.sv
// sdp_ram_rf_1024x32
//   Simple dual-port synchronous RAM with one write port and one read port
//   on a single clock. Collisions are read-first: a read and a write to the
//   same address on the same edge return the old word. Read data is
//   registered. The memory array itself is never reset.
//
//   Optional build macro: SDP_RAM_OUT_REG_EN
//     Adds a second output register after the read register, which makes
//     the read latency two cycles.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset (clears output registers only)
//   we         - write enable
//   write_addr - write word address
//   din        - write data
//   re         - read enable
//   read_addr  - read word address
//   dout       - registered read data
module sdp_ram_rf_1024x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Array has no reset so it maps onto block RAM; writes are dropped
  // while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      r_mem[write_addr] <= din;
    end
  end

  // Non-blocking update of the array gives read-first behaviour on
  // same-address collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (re) begin
      r_rd_data <= r_mem[read_addr];
    end
  end

`ifdef SDP_RAM_OUT_REG_EN
  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_out;

  // Second stage loads only when the first stage took new data on the
  // previous edge, so each stage holds independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_out    <= '0;
    end else begin
      r_rd_vld <= re;
      if (r_rd_vld) begin
        r_out <= r_rd_data;
      end
    end
  end

  assign dout = r_out;
`else
  assign dout = r_rd_data;
`endif

endmodule

// File: tb/tb_sdp_ram_rf_1024x32.sv
// Self-checking bench for sdp_ram_rf_1024x32 with a behavioural model:
// a word array plus a list of read events. The output is the most recent
// read issued at least LAT-1 edges ago since the last reset, else zero.
module tb_sdp_ram_rf_1024x32;

`ifdef SDP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  write_addr = '0;
  logic [31:0] din = '0;
  logic        re = 1'b0;
  logic [9:0]  read_addr = '0;
  logic [31:0] dout;

  int checks = 0;
  int passes = 0;

  sdp_ram_rf_1024x32 #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .DEPTH(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .write_addr(write_addr),
    .din(din),
    .re(re),
    .read_addr(read_addr),
    .dout(dout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned e;
    bit          def;
    logic [31:0] v;
  } rd_t;

  logic [31:0] m_mem [1024];
  bit          m_def [1024];
  rd_t         m_q [$];
  int unsigned m_n = 0;
  bit          m_ok = 1'b0;
  bit          exp_def = 1'b1;
  logic [31:0] exp_val = '0;

  always @(posedge clk) begin
    int keep;
    m_n = m_n + 1;
    if (!rst_n) begin
      m_q.delete();
      m_ok = 1'b1;
    end else begin
      if (re) m_q.push_back('{e: m_n, def: m_def[read_addr], v: m_mem[read_addr]});
      if (we) begin
        m_mem[write_addr] = din;
        m_def[write_addr] = 1'b1;
      end
    end
    exp_def = 1'b1;
    exp_val = '0;
    keep = 0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].e + LAT - 1 <= m_n) begin
        exp_def = m_q[i].def;
        exp_val = m_q[i].v;
        keep = i;
        break;
      end
    end
    while (keep > 0) begin
      void'(m_q.pop_front());
      keep--;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_ok && exp_def) begin
      checks++;
      if (dout === exp_val) passes++;
      else $display("FAIL model_cmp cycle=%0d dout=%h expected=%h", m_n, dout, exp_val);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] fill [1024];

  task automatic cyc(input bit rn, input bit w, input logic [9:0] wa,
                     input logic [31:0] d, input bit r, input logic [9:0] ra);
    @(negedge clk);
    rst_n = rn; we = w; write_addr = wa; din = d; re = r; read_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s dout=%h expected=%h", name, act, req);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with re=1, then release with re=0.
    cyc(1'b0, 1'b1, 10'd1, 32'hDEAD_BEEF, 1'b1, 10'd1);
    cyc(1'b0, 1'b1, 10'd1, 32'hDEAD_BEEF, 1'b1, 10'd1);
    lit("reset_dout", dout, 32'h0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    lit("release_dout", dout, 32'h0);

    // Fill with re=0, then read back.
    for (int i = 0; i < 1024; i++) begin
      fill[i] = $urandom;
      cyc(1'b1, 1'b1, 10'(i), fill[i], 1'b0, 10'($urandom_range(0, 1023)));
    end
    lit("fill_dout_zero", dout, 32'h0);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b0, '0, '0, 1'b1, 10'(i));
    idle(LAT - 1);
    lit("readback_last", dout, fill[1023]);

    // Read-first collision.
    cyc(1'b1, 1'b1, 10'd5, 32'h1111_1111, 1'b0, '0);
    cyc(1'b1, 1'b1, 10'd5, 32'hAAAA_5555, 1'b1, 10'd5);
    idle(LAT - 1);
    lit("collision_old", dout, 32'h1111_1111);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 10'd5);
    idle(LAT - 1);
    lit("collision_new", dout, 32'hAAAA_5555);
    fill[5] = 32'hAAAA_5555;

    // Rewrite everything with re=0 and random read_addr, then read back.
    for (int i = 0; i < 1024; i++) begin
      fill[i] = $urandom;
      cyc(1'b1, 1'b1, 10'(i), fill[i], 1'b0, 10'($urandom_range(0, 1023)));
    end
    lit("concurrent_hold", dout, 32'hAAAA_5555);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b0, '0, '0, 1'b1, 10'(i));
    idle(LAT - 1);
    lit("readback2_last", dout, fill[1023]);

    // Random mixed traffic against the model.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 1), 10'($urandom),
          $urandom, $urandom_range(0, 1), 10'($urandom));
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 1024; i++) fill[i] = m_mem[i];

    // Hold, then mid-run reset with a write to the same address.
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 10'd3);
    idle(LAT - 1);
    lit("hold_read3", dout, fill[3]);
    idle(4);
    lit("hold_after4", dout, fill[3]);
    cyc(1'b0, 1'b1, 10'd3, ~fill[3], 1'b1, 10'd3);
    lit("midreset_dout", dout, 32'h0);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 10'd3);
    idle(LAT - 1);
    lit("midreset_mem3", dout, fill[3]);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdp_ram_rf_1024x32.md
Name: sdp_ram_rf_1024x32

Overview:
Simple dual-port synchronous RAM, 1024 words x 32 bits, with one write port and one read port sharing a single clock.
- Read-first (read-before-write) collision semantics.
- Registered read data.
- Used as a generic on-chip buffer; infers a block RAM on FPGA targets.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 10, address width in bits.
- DEPTH, 1024, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- we  input  1  write enable.
- write_addr  input  ADDR_WIDTH  write word address.
- din  input  DATA_WIDTH  write data.
- re  input  1  read enable.
- read_addr  input  ADDR_WIDTH  read word address.
- dout  output  DATA_WIDTH  registered read data.

Interface notes: one clock (clk); reset is synchronous and active-low (rst_n).

Behaviour:
- All actions are sampled on the rising edge of clk.
- Reset (rst_n=0 at posedge):
  - dout <= 0.
  - Reset has priority over re; no write occurs during reset regardless of we.
  - Memory array contents are not cleared by reset.
- Write: we=1 and rst_n=1 -> mem[write_addr] <= din.
- Read: re=1 and rst_n=1 -> dout <= mem[read_addr] as it was before this edge. Read latency is 1 cycle.
- re=0: dout holds its previous value, including the reset value 0.
- Read-first collision: we=1, re=1 and read_addr==write_addr on the same edge -> dout gets the OLD word; the new din is visible on a read at the next or later edge.
- Different addresses: read and write are fully independent in the same cycle.
- Addresses are always in range (2**ADDR_WIDTH == DEPTH); no wrap or bounds logic is needed.
- Unwritten locations: read data is undefined (X in simulation). No power-up initialisation is required.
- dout is driven only by a flop; there is no combinational path from inputs to dout.
- Reset asserted mid-operation: dout clears on that edge; a write presented on that edge is dropped; normal operation resumes on the first edge with rst_n=1.
- Post-synthesis netlist must match RTL cycle-for-cycle on dout for all defined reads.

Optional Feature:
- Macro: SDP_RAM_OUT_REG_EN.
- Defined:
  - A second output pipeline register is added after the read register.
  - Read latency becomes 2 cycles.
  - The pipeline stage loads whenever the first stage held valid read data the previous cycle; it tracks re delayed by one cycle.
  - Both stages reset to 0 synchronously on rst_n=0.
  - Hold behaviour applies per stage.
- Undefined: single output register, latency 1 as described above.

Test Plan:
- Reset: rst_n=0 for 2 edges with re=1 -> dout==0; release with re=0 -> dout stays 0.
- Fill/readback:
  - Write mem[i]=pseudo-random for i=0..1023 with re=0 -> dout stays 0 throughout.
  - Then read i=0..1023 with we=0, re=1 -> dout equals the word written at i, one cycle after the address is presented.
- Read-first collision: mem[5]=0x11111111; same edge we=1, write_addr=5, din=0xAAAA5555, re=1, read_addr=5 -> dout=0x11111111; next edge read 5 -> dout=0xAAAA5555.
- Concurrent independent ports: write addresses 0..1023 with new data while re=0 and read_addr random -> dout unchanged. Full readback afterwards returns the new data.
- Hold and mid-run reset:
  - Read 3 -> dout=mem[3]; drop re for 4 cycles -> dout holds.
  - Pulse rst_n=0 with we=1, write_addr=3 -> dout=0, and mem[3] is unchanged on the next read.
- With SDP_RAM_OUT_REG_EN defined: repeat the fill/readback case -> data appears 2 cycles after the address; reset clears both stages.
